// File: rtl/systolic_skew_loader_if.sv
// Serial element stream into the systolic skew loader: one element per
// valid/ready transfer, A elements first (row-major), then B (row-major).
interface systolic_skew_loader_if #(
    parameter int width_p = 8
);
    logic               valid_i;
    logic [width_p-1:0] data_i;
    logic               ready_o;

    // Producer side of the element stream.
    modport master (
        output valid_i,
        output data_i,
        input  ready_o
    );

    // Loader side of the element stream.
    modport slave (
        input  valid_i,
        input  data_i,
        output ready_o
    );
endinterface

// File: rtl/systolic_skew_loader.sv
// Systolic array front end. Buffers an H x K matrix A and a K x W matrix B
// arriving as one serial element stream, then feeds the array edges with the
// diagonal skew a systolic multiply needs: row r carries A[r][t-r] and
// column c carries B[t-c][c] at stream cycle t, each lane with its own valid.
// All lane outputs are decoded from registered state, the stream counter and
// the buffers, so nothing on the input side reaches them combinationally.
module systolic_skew_loader #(
    parameter int width_p        = 8,
    parameter int array_width_p  = 2,
    parameter int array_height_p = 2,
    parameter int depth_p        = 2
) (
    input  logic                                clk_i,
    input  logic                                reset_i,
    input  logic                                en_i,
    input  logic                                flush_i,
    systolic_skew_loader_if.slave               in_if,
    output logic [array_height_p*width_p-1:0]   row_data_o,
    output logic [array_height_p-1:0]           row_valid_o,
    output logic [array_width_p*width_p-1:0]    col_data_o,
    output logic [array_width_p-1:0]            col_valid_o,
    output logic                                done_o
);

    localparam int H      = array_height_p;
    localparam int W      = array_width_p;
    localparam int K      = depth_p;
    localparam int A_N    = H * K;
    localparam int B_N    = K * W;
    localparam int MAX_N  = (A_N > B_N) ? A_N : B_N;
    localparam int MAX_HW = (H > W) ? H : W;
    // Last row/column lane finishes K cycles after it starts; the widest edge
    // starts MAX_HW-1 cycles late.
    localparam int T_LEN  = K + MAX_HW - 1;
    localparam int CNT_W  = $clog2(MAX_N + 1);
    localparam int T_W    = $clog2(T_LEN + 1);

    typedef enum logic [1:0] {
        S_LOAD_A = 2'd0,
        S_LOAD_B = 2'd1,
        S_STREAM = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   ld_cnt, ld_cnt_nxt;
    logic [T_W-1:0]     t, t_nxt;
    logic               a_we, b_we;
    logic               ready;
    logic               xfer;

    // Flat row-major buffers: element n of each load lands at index n, so
    // A[r][k] sits at r*K+k and B[k][c] at k*W+c. Never reset; every read is
    // gated by a lane valid, so stale contents cannot leak.
    logic [width_p-1:0] a_mem [A_N];
    logic [width_p-1:0] b_mem [B_N];

    assign ready        = en_i & ~reset_i & ((state == S_LOAD_A) | (state == S_LOAD_B));
    assign in_if.ready_o = ready;
    assign xfer         = in_if.valid_i & ready;

    // Control registers: state and both counters; held whenever next equals current.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state  <= S_LOAD_A;
            ld_cnt <= '0;
            t      <= '0;
        end else begin
            state  <= state_nxt;
            ld_cnt <= ld_cnt_nxt;
            t      <= t_nxt;
        end
    end

    // Next-state logic: loads advance on transfers, stream advances every enabled cycle.
    always_comb begin
        state_nxt  = state;
        ld_cnt_nxt = ld_cnt;
        t_nxt      = t;
        a_we       = 1'b0;
        b_we       = 1'b0;
        if (en_i) begin
            if (flush_i) begin
                // Abort: discard any partial tile; a coincident transfer is dropped.
                state_nxt  = S_LOAD_A;
                ld_cnt_nxt = '0;
                t_nxt      = '0;
            end else begin
                unique case (state)
                    S_LOAD_A: begin
                        if (xfer) begin
                            a_we = 1'b1;
                            if (ld_cnt == CNT_W'(A_N - 1)) begin
                                state_nxt  = S_LOAD_B;
                                ld_cnt_nxt = '0;
                            end else begin
                                ld_cnt_nxt = ld_cnt + 1'b1;
                            end
                        end
                    end
                    S_LOAD_B: begin
                        if (xfer) begin
                            b_we = 1'b1;
                            if (ld_cnt == CNT_W'(B_N - 1)) begin
                                state_nxt  = S_STREAM;
                                ld_cnt_nxt = '0;
                                t_nxt      = '0;
                            end else begin
                                ld_cnt_nxt = ld_cnt + 1'b1;
                            end
                        end
                    end
                    S_STREAM: begin
                        if (t == T_W'(T_LEN - 1)) begin
                            state_nxt = S_DONE;
                            t_nxt     = '0;
                        end else begin
                            t_nxt = t + 1'b1;
                        end
                    end
                    S_DONE: begin
                        state_nxt = S_LOAD_A;
                    end
                    default: begin
                        state_nxt = S_LOAD_A;
                    end
                endcase
            end
        end
    end

    // A buffer write: the element counter selects the row-major slot.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < A_N; i++) begin
            if (a_we && (ld_cnt == CNT_W'(i))) begin
                a_mem[i] <= in_if.data_i;
            end
        end
    end

    // B buffer write: the element counter selects the row-major slot.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < B_N; i++) begin
            if (b_we && (ld_cnt == CNT_W'(i))) begin
                b_mem[i] <= in_if.data_i;
            end
        end
    end

    // Skewed lane decode: lane r (or c) is live when t-r (or t-c) falls in [0, K).
    always_comb begin
        row_data_o  = '0;
        row_valid_o = '0;
        col_data_o  = '0;
        col_valid_o = '0;
        done_o      = 1'b0;
        if (en_i && !reset_i) begin
            if (state == S_STREAM) begin
                for (int r = 0; r < H; r++) begin
                    for (int k = 0; k < K; k++) begin
                        if (t == T_W'(r + k)) begin
                            row_valid_o[r]                   = 1'b1;
                            row_data_o[r*width_p +: width_p] = a_mem[r*K + k];
                        end
                    end
                end
                for (int c = 0; c < W; c++) begin
                    for (int k = 0; k < K; k++) begin
                        if (t == T_W'(c + k)) begin
                            col_valid_o[c]                   = 1'b1;
                            col_data_o[c*width_p +: width_p] = b_mem[k*W + c];
                        end
                    end
                end
            end
            done_o = (state == S_DONE);
        end
    end

endmodule
